// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide writing HI/LO.
//
// Ports:
//   clk, reset (sync, active-low)
//   start, A, B, ALUControl : request, latched when idle
//   Result, Zero, Overflow, DivZero : registered status, held
//   busy : operation in progress, start ignored
//   done : one-cycle completion pulse
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LUI   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_FIN
    } state_t;

    state_t st, st_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_step;
    logic [WIDTH-1:0]   ma, mb;
    logic [WIDTH-1:0]   hi, lo;
    logic               is_div, neg_q, neg_r;

    logic op_md, op_div, op_signed, div0, accept, last;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        op_md = (ALUControl == OP_MULT) || (ALUControl == OP_MULTU)
             || (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU);
        op_div    = (ALUControl == OP_DIV) || (ALUControl == OP_DIVU);
        op_signed = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
        div0   = op_div && (B == '0);
        accept = (st == S_IDLE) && start;
        last   = (cnt == CNT_W'(WIDTH - 1));
        mag_a  = (op_signed && A[WIDTH-1]) ? -A : A;
        mag_b  = (op_signed && B[WIDTH-1]) ? -B : B;
    end

    // Single-cycle datapath, evaluated on the live inputs at accept.
    logic [WIDTH-1:0] sum, dif, alu_res;
    logic             alu_ovf;

    always_comb begin
        sum     = A + B;
        dif     = A - B;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUControl)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_NOR:  alu_res = ~(A | B);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1])
                       && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1])
                       && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  alu_res[0] = $signed(A) < $signed(B);
            OP_SLTU: alu_res[0] = A < B;
            OP_LUI:  alu_res = B << (WIDTH / 2);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // One iteration step. Multiply keeps {acc, multiplier} in p and
    // shifts right; divide keeps {rem, quotient} in p and shifts left.
    logic [WIDTH:0] m_sum, d_sh, d_dif;

    always_comb begin
        m_sum = {1'b0, p[2*WIDTH-1:WIDTH]}
              + (p[0] ? {1'b0, ma} : '0);
        d_sh  = p[2*WIDTH-1:WIDTH-1];
        d_dif = d_sh - {1'b0, mb};
        if (is_div) begin
            if (!d_dif[WIDTH])
                p_step = {d_dif[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
            else
                p_step = {d_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
        end else begin
            p_step = {m_sum, p[WIDTH-1:1]};
        end
    end

    // Sign restoration on the final step's magnitudes.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, fin_hi, fin_lo;

    always_comb begin
        prod_fix = neg_q ? -p_step : p_step;
        q_fix    = neg_q ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
        r_fix    = neg_r ? -p_step[2*WIDTH-1:WIDTH]
                         : p_step[2*WIDTH-1:WIDTH];
        fin_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
        fin_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset)
            st <= S_IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE: begin
                if (start)
                    st_nxt = (op_md && !div0) ? S_ITER : S_EXEC;
            end
            S_EXEC: st_nxt = S_IDLE;
            S_ITER: if (last) st_nxt = S_FIN;
            S_FIN:  st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (st != S_IDLE);
        done = (st == S_EXEC) || (st == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            p        <= '0;
            ma       <= '0;
            mb       <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            Result   <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            DivZero  <= 1'b0;
        end else if (accept) begin
            if (div0) begin
                hi       <= A;
                lo       <= '1;
                Result   <= '1;
                Zero     <= 1'b0;
                Overflow <= 1'b0;
                DivZero  <= 1'b1;
            end else if (op_md) begin
                cnt    <= '0;
                ma     <= mag_a;
                mb     <= mag_b;
                p      <= {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
                is_div <= op_div;
                neg_q  <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                neg_r  <= op_signed && A[WIDTH-1];
            end else begin
                Result   <= alu_res;
                Zero     <= (alu_res == '0);
                Overflow <= alu_ovf;
                DivZero  <= 1'b0;
            end
        end else if (st == S_ITER) begin
            p   <= p_step;
            cnt <= cnt + 1'b1;
            if (last) begin
                cnt      <= '0;
                hi       <= fin_hi;
                lo       <= fin_lo;
                Result   <= fin_lo;
                Zero     <= (fin_lo == '0);
                Overflow <= 1'b0;
                DivZero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: reference model feeds a scoreboard
// queue, DUT completions are popped and compared.
module tb_alu_multicycle;

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001;
    localparam logic [3:0] ADD = 4'b0010, LUI = 4'b0011;
    localparam logic [3:0] SUB = 4'b0110, SLT = 4'b0111;
    localparam logic [3:0] SLTU = 4'b1000, MULT = 4'b1001;
    localparam logic [3:0] MULTU = 4'b1010, DIV = 4'b1011;
    localparam logic [3:0] NOR_ = 4'b1100, DIVU = 4'b1101;
    localparam logic [3:0] MFHI = 4'b1110, MFLO = 4'b1111;
    localparam logic [3:0] BAD = 4'b0101;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        dz;
        logic [7:0]  lat;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] A, B;
    logic [3:0]  ALUControl;
    logic [31:0] Result;
    logic        Zero, Overflow, DivZero, busy, done;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    rec_t sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_multicycle dut (
        .clk(clk), .reset(reset), .start(start),
        .A(A), .B(B), .ALUControl(ALUControl),
        .Result(Result), .Zero(Zero), .Overflow(Overflow),
        .DivZero(DivZero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic rec_t model(logic [3:0] op, logic [31:0] a,
                                   logic [31:0] b);
        rec_t e;
        logic signed [63:0] sa, sbb;
        logic [63:0] pu;
        int ia, ib;
        e = '0;
        e.lat = 8'd1;
        case (op)
            AND_: e.res = a & b;
            OR_:  e.res = a | b;
            NOR_: e.res = ~(a | b);
            ADD: begin
                e.res = a + b;
                e.ov = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            SUB: begin
                e.res = a - b;
                e.ov = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
            LUI:  e.res = b << 16;
            MFHI: e.res = m_hi;
            MFLO: e.res = m_lo;
            MULT, MULTU: begin
                if (op == MULT) begin
                    sa = {{32{a[31]}}, a};
                    sbb = {{32{b[31]}}, b};
                    pu = sa * sbb;
                end else begin
                    pu = {32'd0, a} * {32'd0, b};
                end
                m_hi = pu[63:32];
                m_lo = pu[31:0];
                e.res = m_lo;
                e.lat = 8'd33;
            end
            DIV, DIVU: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = '1;
                    e.dz = 1'b1;
                end else begin
                    if (op == DIV) begin
                        ia = a;
                        ib = b;
                        m_lo = ia / ib;
                        m_hi = ia % ib;
                    end else begin
                        m_lo = a / b;
                        m_hi = a % b;
                    end
                    e.lat = 8'd33;
                end
                e.res = m_lo;
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    function automatic string fmt(rec_t r);
        return $sformatf("res=%h z=%b ov=%b dz=%b lat=%0d",
                         r.res, r.z, r.ov, r.dz, r.lat);
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke,
                         output rec_t o);
        int t0;
        sb.push_back(model(op, a, b));
        o = '0;
        o.lat = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b1;
        ALUControl = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                o.lat = 8'(cyc - t0 + 1);
                break;
            end
            start = poke && (i == 3 || i == 10);
            if (start) begin
                A = ~a;
                B = a;
                ALUControl = ADD;
            end
        end
        start = 1'b0;
        o.res = Result;
        o.z = Zero;
        o.ov = Overflow;
        o.dz = DivZero;
    endtask

    task automatic test_reset();
        rec_t o, e;
        reset = 1'b0;
        start = 1'b1;
        ALUControl = ADD;
        A = 32'd1;
        B = 32'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({Result, Zero, Overflow, DivZero, busy, done} !==
            {32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got res=%h z=%b ov=%b dz=%b busy=%b done=%b, want res=0 z=1 ov=0 dz=0 busy=0 done=0",
                     Result, Zero, Overflow, DivZero, busy, done);
        end
        start = 1'b0;
        reset = 1'b1;
        do_op(MFHI, 0, 0, 0, o);
        e = sb.pop_front();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_hi: got %s, want %s", fmt(o), fmt(e));
        end
        do_op(MFLO, 0, 0, 0, o);
        e = sb.pop_front();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_lo: got %s, want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_add();
        rec_t o, e;
        logic [3:0]  op[3];
        logic [31:0] a[3], b[3];
        op = '{ADD, SUB, ADD};
        a = '{32'h7FFFFFFF, 32'h80000000, 32'h12345678};
        b = '{32'd1, 32'd1, 32'h11111111};
        foreach (op[i]) begin
            do_op(op[i], a[i], b[i], 0, o);
            e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL add[%0d]: got %s, want %s",
                         i, fmt(o), fmt(e));
            end
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_exec: got %b, want 1", busy);
        end
        @(negedge clk);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_after: got busy=%b done=%b, want 0 0",
                     busy, done);
        end
    endtask

    task automatic test_mult();
        rec_t o, e;
        logic [3:0]  op[5];
        logic [31:0] a[5], b[5];
        op = '{MULT, MFHI, MULTU, MFHI, MULT};
        a = '{32'hFFFFFFFE, 0, 32'h00010000, 0, 32'hFFFF0001};
        b = '{32'd3, 0, 32'h00010000, 0, 32'h80000000};
        foreach (op[i]) begin
            do_op(op[i], a[i], b[i], i == 0, o);
            e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mult[%0d]: got %s, want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_div();
        rec_t o, e;
        logic [3:0]  op[7];
        logic [31:0] a[7], b[7];
        op = '{DIV, MFHI, DIVU, MFHI, DIV, MFHI, MFLO};
        a = '{32'hFFFFFFF9, 0, 32'd100, 0, 32'd7, 0, 0};
        b = '{32'd2, 0, 32'd7, 0, 32'hFFFFFFFE, 0, 0};
        foreach (op[i]) begin
            do_op(op[i], a[i], b[i], i == 2, o);
            e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL div[%0d]: got %s, want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_divzero();
        rec_t o, e;
        logic [3:0]  op[6];
        logic [31:0] a[6], b[6];
        op = '{DIVU, SUB, MFHI, DIV, MFHI, MFLO};
        a = '{32'd5, 32'd5, 0, 32'hFFFFFF00, 0, 0};
        b = '{32'd0, 32'd5, 0, 32'd0, 0, 0};
        foreach (op[i]) begin
            do_op(op[i], a[i], b[i], 0, o);
            e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL divzero[%0d]: got %s, want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_reset_abort();
        rec_t o, e;
        int n_done, n_busy;
        logic [3:0]  op[3];
        logic [31:0] b[3];
        @(posedge clk);
        #1;
        start = 1'b1;
        ALUControl = MULTU;
        A = '1;
        B = '1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b1;
        ALUControl = ADD;
        A = 32'd1;
        B = 32'd1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        m_hi = '0;
        m_lo = '0;
        n_done = 0;
        n_busy = 0;
        repeat (40) begin
            @(negedge clk);
            n_done += int'(done);
            n_busy += int'(busy);
        end
        n_tests++;
        if (n_done !== 0 || n_busy !== 0) begin
            n_fail++;
            $display("FAIL abort_idle: got done=%0d busy=%0d cycles, want 0 0",
                     n_done, n_busy);
        end
        n_tests++;
        if ({Result, Zero, Overflow, DivZero} !==
            {32'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_state: got res=%h z=%b ov=%b dz=%b, want 0 1 0 0",
                     Result, Zero, Overflow, DivZero);
        end
        op = '{MFHI, MFLO, LUI};
        b = '{0, 0, 32'h1234};
        foreach (op[i]) begin
            do_op(op[i], 0, b[i], 0, o);
            e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort[%0d]: got %s, want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_slt();
        rec_t o, e;
        logic [3:0]  op[4];
        logic [31:0] a[4], b[4];
        op = '{SLT, SLTU, SLT, BAD};
        a = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
        b = '{32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        foreach (op[i]) begin
            do_op(op[i], a[i], b[i], 0, o);
            e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL slt[%0d]: got %s, want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t o, e;
        logic [3:0] ops[12];
        logic [3:0] op;
        logic [31:0] a, b;
        ops = '{AND_, OR_, ADD, SUB, SLT, SLTU, NOR_, LUI,
                MFHI, MFLO, BAD, MULTU};
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 11)];
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            do_op(op, a, b, 0, o);
            e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d] op=%b a=%h b=%h: got %s, want %s",
                         i, op, a, b, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        ALUControl = '0;
        test_reset();
        test_add();
        test_mult();
        test_div();
        test_divzero();
        test_reset_abort();
        test_slt();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (even, >= 8).
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (2**CNT_W > WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request: latch A, B, ALUControl this cycle.
REQ-006 SHALL have port A  input  WIDTH  first operand.
REQ-007 SHALL have port B  input  WIDTH  second operand.
REQ-008 SHALL have port ALUControl  input  4  operation select.
REQ-009 SHALL have port Result  output  WIDTH  registered result, held until next completion.
REQ-010 SHALL have port Zero  output  1  high when Result == 0, registered with Result.
REQ-011 SHALL have port Overflow  output  1  signed overflow of ADD/SUB, else 0.
REQ-012 SHALL have port DivZero  output  1  last DIV/DIVU had B == 0.
REQ-013 SHALL have port busy  output  1  operation in progress; start ignored.
REQ-014 SHALL have port done  output  1  one-cycle pulse when Result/HI/LO updated.

Function
REQ-015 SHALL decode ALUControl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1100 NOR, 0011 LUI (B << WIDTH/2), 1001 MULT, 1010 MULTU, 1011 DIV, 1101 DIVU, 1110 MFHI, 1111 MFLO; other codes produce Result 0.
REQ-016 SHALL implement FSM IDLE -> EXEC (single-cycle ops) or IDLE -> ITER (MULT/MULTU/DIV/DIVU) -> FIN -> IDLE.
REQ-017 SHALL, in IDLE with start=1, latch operands/op; start with busy=1 SHALL be ignored and not corrupt state.
REQ-018 SHALL complete single-cycle ops with done=1 and new Result in the cycle after start (latency 1); busy=1 only during that cycle.
REQ-019 SHALL perform MULT/MULTU as WIDTH-cycle shift-add on magnitudes, DIV/DIVU as WIDTH-cycle restoring division; done asserted WIDTH+1 cycles after start.
REQ-020 SHALL write MULT/MULTU 2*WIDTH product to HI (upper) and LO (lower); DIV/DIVU quotient to LO, remainder to HI.
REQ-021 SHALL negate signed product when operand signs differ; signed quotient sign = sign(A) xor sign(B), remainder sign = sign(A) (truncating division).
REQ-022 SHALL, for DIV/DIVU with B == 0, skip iteration: LO = all ones, HI = A, DivZero=1, done 1 cycle after start.
REQ-023 SHALL set Result = LO for MULT/MULTU/DIV/DIVU completions; MFHI/MFLO SHALL return HI/LO as single-cycle ops.
REQ-024 SHALL set Overflow = 1 only for ADD/SUB with signed overflow; Result still holds wrapped WIDTH-bit sum.
REQ-025 SHALL clear DivZero on every completion other than a DIV/DIVU by zero.
REQ-026 SHALL compute all arithmetic modulo 2**WIDTH; SLT/SLTU Result is 1 or 0 zero-extended.
REQ-027 SHALL leave HI/LO unchanged by non-mult/div ops; Result/Zero/Overflow/DivZero hold between completions.

Reset
REQ-028 SHALL, when reset=0 at a clock edge, force FSM IDLE, busy=0, done=0, Result=0, Zero=1, Overflow=0, DivZero=0, HI=0, LO=0, counter=0.
REQ-029 SHALL abort any in-progress iteration on reset without asserting done; start during reset SHALL be ignored.
REQ-030 SHALL accept start in the first cycle after reset deasserts.

Verification
REQ-031 ADD A=0x7FFFFFFF, B=1 -> 1 cycle later done=1, Result=0x80000000, Overflow=1, Zero=0.
REQ-032 MULT A=0xFFFFFFFE (-2), B=3 -> done at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFFA, Result=LO; start pulses during busy ignored.
REQ-033 DIV A=0xFFFFFFF9 (-7), B=2 -> done at cycle 33, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); then MFHI -> Result=0xFFFFFFFF.
REQ-034 DIVU A=5, B=0 -> done at cycle 1, LO=0xFFFFFFFF, HI=5, DivZero=1; next SUB 5-5 -> Result=0, Zero=1, DivZero=0.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF, reset=0 at cycle 10 -> no done, busy=0, HI=LO=0; LUI B=0x1234 after release -> Result=0x12340000.
REQ-036 SLT A=0xFFFFFFFF, B=1 -> Result=1; SLTU same operands -> Result=0, Zero=1.
